// File: rtl/approx_add_sched_pkg.sv
// Shared types and constants for the approximate-adder sequencing controller.
package approx_add_sched_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned LVL_W  = 2;
    localparam int unsigned MASK_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Index by accuracy level; a set bit makes that lower nibble exact.
    localparam logic [3:0][MASK_W-1:0] LEVEL_MASK = {3'b111, 3'b110, 3'b100, 3'b000};

    function automatic logic [MASK_W-1:0] level_to_mask(input logic [LVL_W-1:0] lvl);
        return LEVEL_MASK[lvl];
    endfunction

endpackage

// File: rtl/approx_add_sched_adder.sv
// 16-bit low-power approximate adder. The top nibble is always exact; each
// lower nibble is exact when its mask bit is set, otherwise it is the OR of
// the operand nibbles and passes no carry upward.
module approx_add_sched_adder
    import approx_add_sched_pkg::*;
(
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [MASK_W-1:0] mask,
    output logic [DATA_W-1:0] out
);

    logic [4:0] nib;
    logic       carry;

    // Ripple nibble by nibble, breaking the carry chain at approximate nibbles.
    always_comb begin
        out   = '0;
        nib   = '0;
        carry = 1'b0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (mask[i]) begin
                nib = {1'b0, in1[4*i +: 4]} + {1'b0, in2[4*i +: 4]} + {4'b0, carry};
                out[4*i +: 4] = nib[3:0];
                carry         = nib[4];
            end else begin
                out[4*i +: 4] = in1[4*i +: 4] | in2[4*i +: 4];
                carry         = 1'b0;
            end
        end
        nib = {1'b0, in1[DATA_W-1 -: 4]} + {1'b0, in2[DATA_W-1 -: 4]} + {4'b0, carry};
        out[DATA_W-1 -: 4] = nib[3:0];
    end

endmodule

// File: rtl/approx_add_sched.sv
// Sequencing controller for the 16-bit approximate adder: one operation in
// flight, IDLE -> CALC -> DONE. Optional error monitor that raises/lowers the
// accuracy floor per window is enabled with macro ERR_MON_EN.
module approx_add_sched
    import approx_add_sched_pkg::*;
#(
    parameter int unsigned ERR_THRESH = 4,
    parameter int unsigned WIN_LEN    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [LVL_W-1:0]  level,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic [LVL_W-1:0]  sum_level,
    output logic [LVL_W-1:0]  floor_level
);

    if ((WIN_LEN < 2) || ((WIN_LEN & (WIN_LEN - 1)) != 0) || (ERR_THRESH < 1)) begin : g_cfg_check
        $error("approx_add_sched: WIN_LEN must be a power of two >= 2 and ERR_THRESH >= 1");
    end

    state_t            state_q, state_d;
    logic              accept;
    logic [DATA_W-1:0] a_q, b_q, approx_sum, sum_q;
    logic [LVL_W-1:0]  lvl_q, sum_level_q, eff_level;

    assign accept = in_valid && in_ready;

    approx_add_sched_adder u_adder (
        .in1  (a_q),
        .in2  (b_q),
        .mask (level_to_mask(lvl_q)),
        .out  (approx_sum)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_d = CALC;
            end
            CALC: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture at accept, result capture on the CALC->DONE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            lvl_q       <= '0;
            sum_q       <= '0;
            sum_level_q <= '0;
        end else begin
            if (accept) begin
                a_q   <= in1;
                b_q   <= in2;
                lvl_q <= eff_level;
            end
            if (state_q == CALC) begin
                sum_q       <= approx_sum;
                sum_level_q <= lvl_q;
            end
        end
    end

    assign sum       = sum_q;
    assign sum_level = sum_level_q;

`ifdef ERR_MON_EN
    localparam int unsigned OCW = $clog2(WIN_LEN);
    localparam int unsigned MCW = $clog2(WIN_LEN + 1);

    logic [DATA_W-1:0] exact_sum;
    logic              mismatch;
    logic              win_end;
    logic [OCW-1:0]    op_cnt_q;
    logic [MCW-1:0]    mis_cnt_q, mis_total;
    logic [LVL_W-1:0]  floor_q;

    assign exact_sum = a_q + b_q;
    assign mismatch  = (exact_sum != approx_sum);
    // Window decision includes the operation completing on this edge.
    assign mis_total = (mismatch && (mis_cnt_q != '1)) ? mis_cnt_q + 1'b1 : mis_cnt_q;
    assign win_end   = (op_cnt_q == OCW'(WIN_LEN - 1));

    // Window counters and accuracy floor, advanced once per completed operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt_q  <= '0;
            mis_cnt_q <= '0;
            floor_q   <= '0;
        end else if (state_q == CALC) begin
            if (win_end) begin
                op_cnt_q  <= '0;
                mis_cnt_q <= '0;
                if (32'(mis_total) >= ERR_THRESH) begin
                    if (floor_q != '1) floor_q <= floor_q + 1'b1;
                end else if (mis_total == '0) begin
                    if (floor_q != '0) floor_q <= floor_q - 1'b1;
                end
            end else begin
                op_cnt_q  <= op_cnt_q + 1'b1;
                mis_cnt_q <= mis_total;
            end
        end
    end

    assign floor_level = floor_q;
    assign eff_level   = (level > floor_q) ? level : floor_q;
`else
    assign floor_level = '0;
    assign eff_level   = level;
`endif

endmodule
